l2_lookup_pipe: RTL

- Parametrised, pipelined successor to the single-cycle L2 tag lookup.
- Compares a request tag against all ways of one set using per-word Spandex states. Returns hit way, empty way, round-robin victim way, and shared/owned word masks for the hit way.
- Two-stage valid/ready pipeline, one request per cycle. Sits between the set read (tags/states buffers) and the L2 FSM.

---
 rtl/l2_lookup_pipe_pkg.sv | 18 +
 rtl/l2_lookup_prio_enc.sv | 23 ++
 rtl/l2_lookup_pipe.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_lookup_pipe_pkg.sv
// rtl/l2_lookup_pipe_pkg.sv - Spandex state and lookup-mode encodings shared by the L2 lookup pipe
package l2_lookup_pipe_pkg;

  typedef enum logic [2:0] {
    SPX_I = 3'd0,
    SPX_S = 3'd1,
    SPX_R = 3'd2,
    SPX_V = 3'd3
  } spx_state_e;

  typedef enum logic {
    L2_LOOKUP     = 1'b0,
    L2_LOOKUP_FWD = 1'b1
  } l2_lookup_mode_e;

  localparam int SPX_STATE_W = 3;

endpackage

// File: rtl/l2_lookup_prio_enc.sv
// rtl/l2_lookup_prio_enc.sv - lowest-set-bit encoder with found flag over a WAYS-wide vector
module l2_lookup_prio_enc #(
  parameter int WAYS  = 8,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  i_vec,
  output logic [WAY_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = WAY_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_lookup_pipe.sv
// rtl/l2_lookup_pipe.sv - two-stage valid/ready L2 tag lookup with round-robin victim pointer
// Optional: define L2_LOOKUP_MULTIHIT_CHK_EN to add the sticky err_multihit output.
module l2_lookup_pipe #(
  parameter int WAYS    = 8,
  parameter int WAY_W   = $clog2(WAYS),
  parameter int TAG_W   = 20,
  parameter int WORDS   = 4,
  parameter int STATE_W = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_mode,
  input  logic [TAG_W-1:0]             req_tag,
  input  logic [WAYS*TAG_W-1:0]        req_tags,
  input  logic [WAYS*WORDS*STATE_W-1:0] req_states,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_mode,
  output logic                         rsp_tag_hit,
  output logic [WAY_W-1:0]             rsp_way_hit,
  output logic                         rsp_empty_found,
  output logic [WAY_W-1:0]             rsp_empty_way,
  output logic [WAY_W-1:0]             rsp_evict_way,
  output logic [WORDS-1:0]             rsp_word_mask_shared,
  output logic [WORDS-1:0]             rsp_word_mask_owned
`ifdef L2_LOOKUP_MULTIHIT_CHK_EN
  ,
  output logic                         err_multihit
`endif
);

  import l2_lookup_pipe_pkg::*;

  localparam int LINE_W = WORDS * STATE_W;

  typedef logic [WAYS-1:0]  way_vec_t;
  typedef logic [WORDS-1:0] word_mask_t;

  logic                         w_s1_adv;
  logic                         w_s2_adv;
  logic                         w_rsp_fire;
  way_vec_t                     w_hit_vec;
  way_vec_t                     w_empty_vec;
  logic [WAYS*LINE_W-1:0]       w_qual_states;

  logic                         r_s1_valid;
  logic                         r_s1_mode;
  way_vec_t                     r_s1_hit;
  way_vec_t                     r_s1_empty;
  logic [WAYS*LINE_W-1:0]       r_s1_states;

  logic [WAY_W-1:0]             w_hit_idx;
  logic                         w_hit_found;
  logic [WAY_W-1:0]             w_empty_idx;
  logic                         w_empty_found;
  logic [LINE_W-1:0]            w_sel_line;
  word_mask_t                   w_owned;
  word_mask_t                   w_shared;

  logic                         r_s2_valid;
  logic                         r_rsp_mode;
  logic                         r_rsp_tag_hit;
  logic [WAY_W-1:0]             r_rsp_way_hit;
  logic                         r_rsp_empty_found;
  logic [WAY_W-1:0]             r_rsp_empty_way;
  logic [WAY_W-1:0]             r_rsp_evict_way;
  word_mask_t                   r_rsp_shared;
  word_mask_t                   r_rsp_owned;
  logic [WAY_W-1:0]             r_evict_ptr;

  assign w_s2_adv   = !r_s2_valid || rsp_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign req_ready  = w_s1_adv;
  assign w_rsp_fire = r_s2_valid && rsp_ready;

  // Per-way compare; states of non-hit ways are zeroed (SPX_I) so a no-hit
  // response naturally decodes to empty masks in the second stage.
  always_comb begin
    w_hit_vec     = '0;
    w_empty_vec   = '0;
    w_qual_states = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_empty_vec[i] = 1'b1;
      for (int j = 0; j < WORDS; j++) begin
        if (req_states[(i*WORDS+j)*STATE_W +: STATE_W] != STATE_W'(SPX_I)) begin
          w_empty_vec[i] = 1'b0;
        end
      end
      w_hit_vec[i] = (req_tags[i*TAG_W +: TAG_W] == req_tag) && !w_empty_vec[i];
      if (w_hit_vec[i]) begin
        w_qual_states[i*LINE_W +: LINE_W] = req_states[i*LINE_W +: LINE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_hit    <= '0;
      r_s1_empty  <= '0;
      r_s1_states <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= req_valid;
      if (req_valid) begin
        r_s1_mode   <= req_mode;
        r_s1_hit    <= w_hit_vec;
        r_s1_empty  <= w_empty_vec;
        r_s1_states <= w_qual_states;
      end
    end
  end

  l2_lookup_prio_enc #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_hit_enc (
    .i_vec   (r_s1_hit),
    .o_idx   (w_hit_idx),
    .o_found (w_hit_found)
  );

  l2_lookup_prio_enc #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_empty_enc (
    .i_vec   (r_s1_empty),
    .o_idx   (w_empty_idx),
    .o_found (w_empty_found)
  );

  always_comb begin
    w_sel_line = r_s1_states[int'(w_hit_idx)*LINE_W +: LINE_W];
    w_owned    = '0;
    w_shared   = '0;
    for (int j = 0; j < WORDS; j++) begin
      if (w_sel_line[j*STATE_W +: STATE_W] == STATE_W'(SPX_R)) begin
        w_owned[j]  = 1'b1;
        w_shared[j] = 1'b1;
      end else if (w_sel_line[j*STATE_W +: STATE_W] == STATE_W'(SPX_S)) begin
        w_shared[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid        <= 1'b0;
      r_rsp_mode        <= 1'b0;
      r_rsp_tag_hit     <= 1'b0;
      r_rsp_way_hit     <= '0;
      r_rsp_empty_found <= 1'b0;
      r_rsp_empty_way   <= '0;
      r_rsp_evict_way   <= '0;
      r_rsp_shared      <= '0;
      r_rsp_owned       <= '0;
      r_evict_ptr       <= '0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rsp_mode        <= r_s1_mode;
          r_rsp_tag_hit     <= w_hit_found;
          r_rsp_way_hit     <= w_hit_idx;
          r_rsp_empty_found <= w_empty_found && (r_s1_mode == L2_LOOKUP);
          r_rsp_empty_way   <= (r_s1_mode == L2_LOOKUP) ? w_empty_idx : '0;
          r_rsp_evict_way   <= r_evict_ptr;
          r_rsp_shared      <= w_shared;
          r_rsp_owned       <= w_owned;
        end
      end
      // Only a LOOKUP that must allocate by eviction consumes a victim slot.
      if (w_rsp_fire && (r_rsp_mode == L2_LOOKUP) && !r_rsp_tag_hit && !r_rsp_empty_found) begin
        r_evict_ptr <= r_evict_ptr + WAY_W'(1);
      end
    end
  end

  assign rsp_valid            = r_s2_valid;
  assign rsp_mode             = r_rsp_mode;
  assign rsp_tag_hit          = r_rsp_tag_hit;
  assign rsp_way_hit          = r_rsp_way_hit;
  assign rsp_empty_found      = r_rsp_empty_found;
  assign rsp_empty_way        = r_rsp_empty_way;
  assign rsp_evict_way        = r_rsp_evict_way;
  assign rsp_word_mask_shared = r_rsp_shared;
  assign rsp_word_mask_owned  = r_rsp_owned;

`ifdef L2_LOOKUP_MULTIHIT_CHK_EN
  logic r_err_multihit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_multihit <= 1'b0;
    end else if (r_s1_valid && w_s2_adv && |(r_s1_hit & (r_s1_hit - way_vec_t'(1)))) begin
      r_err_multihit <= 1'b1;
    end
  end

  assign err_multihit = r_err_multihit;
`endif

endmodule
